// File: rtl/avg_ctrl_pkg.sv
// avg_ctrl_pkg: shared state encoding, default depth limit and depth clamp for the averaging sequencer
package avg_ctrl_pkg;
    localparam int MAX_LOG_AVGS_DEF = 7;
    typedef enum logic [1:0] {IDLE, SYNC, ACCUM, STOPPING} state_t;
    function automatic int clamp_log_avgs(input int n, input int max_log);
        return (n > max_log) ? max_log : n;
    endfunction
endpackage

// File: rtl/dump_handshake.sv
// dump_handshake: delays each acc_dump by DUMP_LAT cycles into a pkt_valid/pkt_ready offer and flags overruns
// ports: clk, arest (async, active-high); acc_dump, pkt_ready, overflow_clr in; pkt_valid, overflow (sticky) out
module dump_handshake #(
    parameter int DUMP_LAT = 2
) (
    input  logic clk,
    input  logic arest,
    input  logic acc_dump,
    input  logic pkt_ready,
    input  logic overflow_clr,
    output logic pkt_valid,
    output logic overflow
);
    localparam int LW = $clog2(DUMP_LAT + 1);
    logic [LW-1:0] lat_cnt;
    logic xfer;
    assign xfer = pkt_valid && pkt_ready;
    // The dump cycle itself counts as the first latency cycle, so pkt_valid rises DUMP_LAT cycles after acc_dump.
    always_ff @(posedge clk or posedge arest) begin
        if (arest) begin
            lat_cnt <= '0;
            pkt_valid <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (acc_dump) begin
                lat_cnt <= LW'(DUMP_LAT - 1);
                pkt_valid <= DUMP_LAT == 1;
            end else if (lat_cnt != '0) begin
                lat_cnt <= lat_cnt - LW'(1);
                pkt_valid <= lat_cnt == LW'(1);
            end else if (xfer) begin
                pkt_valid <= 1'b0;
            end
            overflow <= (acc_dump && ((pkt_valid && !pkt_ready) || lat_cnt != '0)) || (overflow && !overflow_clr);
        end
    end
endmodule

// File: rtl/avg_window_sequencer.sv
// avg_window_sequencer: frames FFT beats into 2^n windows, drives accumulator enable/clear/dump and the output handshake
// ports: clk, arest (async, active-high); enable, n_avgs_cfg, fft_valid, fft_last, pkt_ready, overflow_clr in;
//        acc_en, acc_clr, acc_dump, pkt_valid, n_avgs_active, win_cnt, overflow out
module avg_window_sequencer
    import avg_ctrl_pkg::*;
#(
    parameter int MAX_LOG_AVGS = MAX_LOG_AVGS_DEF,
    parameter int AVG_W = 3,
    parameter int DUMP_LAT = 2,
    parameter int WIN_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 arest,
    input  logic                 enable,
    input  logic [AVG_W-1:0]     n_avgs_cfg,
    input  logic                 fft_valid,
    input  logic                 fft_last,
    output logic                 acc_en,
    output logic                 acc_clr,
    output logic                 acc_dump,
    output logic                 pkt_valid,
    input  logic                 pkt_ready,
    output logic [AVG_W-1:0]     n_avgs_active,
    output logic [WIN_CNT_W-1:0] win_cnt,
    output logic                 overflow,
    input  logic                 overflow_clr
);
    localparam int FW = MAX_LOG_AVGS + 1;
    state_t state, state_nxt;
    logic [FW-1:0] frame_cnt;
    logic [AVG_W-1:0] cfg_clamped;
    logic first_beat, running, beat_last, win_done, dump_nxt;
    assign cfg_clamped = AVG_W'(clamp_log_avgs(int'(n_avgs_cfg), MAX_LOG_AVGS));
    assign running = state == ACCUM || state == STOPPING;
    assign beat_last = running && fft_valid && fft_last;
    assign win_done = frame_cnt == FW'((1 << n_avgs_active) - 1);
    assign dump_nxt = beat_last && win_done;
    assign acc_en = running && fft_valid;
    assign acc_clr = acc_en && first_beat && frame_cnt == '0;
    // Stopping between frames (no beat of the next frame seen yet) returns straight to IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     state_nxt = enable ? SYNC : IDLE;
            SYNC:     state_nxt = !enable ? IDLE : (fft_valid && fft_last) ? ACCUM : SYNC;
            ACCUM:    state_nxt = enable ? ACCUM : (beat_last || (first_beat && !fft_valid)) ? IDLE : STOPPING;
            STOPPING: state_nxt = beat_last ? IDLE : STOPPING;
        endcase
    end
    always_ff @(posedge clk or posedge arest) begin
        if (arest) begin
            state <= IDLE;
            frame_cnt <= '0;
            first_beat <= 1'b0;
            n_avgs_active <= '0;
            win_cnt <= '0;
            acc_dump <= 1'b0;
        end else begin
            state <= state_nxt;
            acc_dump <= dump_nxt;
            if ((state == IDLE && enable) || dump_nxt) n_avgs_active <= cfg_clamped;
            if (dump_nxt) win_cnt <= win_cnt + WIN_CNT_W'(1);
            if (!running) frame_cnt <= '0;
            else if (beat_last) frame_cnt <= win_done ? '0 : frame_cnt + FW'(1);
            if (state == SYNC) first_beat <= 1'b1;
            else if (acc_en) first_beat <= fft_last;
        end
    end
    dump_handshake #(.DUMP_LAT(DUMP_LAT)) u_dump (
        .clk(clk),
        .arest(arest),
        .acc_dump(acc_dump),
        .pkt_ready(pkt_ready),
        .overflow_clr(overflow_clr),
        .pkt_valid(pkt_valid),
        .overflow(overflow)
    );
endmodule

// File: tb/tb_avg_window_sequencer.sv
// tb_avg_window_sequencer: directed self-checking bench for avg_window_sequencer
module tb_avg_window_sequencer;
    import avg_ctrl_pkg::*;
    logic clk = 1'b0;
    logic arest, enable, fft_valid, fft_last, pkt_ready, overflow_clr;
    logic [3:0] n_avgs_cfg;
    logic acc_en, acc_clr, acc_dump, pkt_valid, overflow;
    logic [3:0] n_avgs_active;
    logic [15:0] win_cnt;
    logic s_en, s_clr, s_dump, s_pv, s_ovf;
    logic [3:0] s_nav;
    logic [15:0] s_win;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    avg_window_sequencer #(.MAX_LOG_AVGS(7), .AVG_W(4), .DUMP_LAT(2), .WIN_CNT_W(16)) dut (
        .clk(clk), .arest(arest), .enable(enable), .n_avgs_cfg(n_avgs_cfg),
        .fft_valid(fft_valid), .fft_last(fft_last), .acc_en(acc_en), .acc_clr(acc_clr),
        .acc_dump(acc_dump), .pkt_valid(pkt_valid), .pkt_ready(pkt_ready),
        .n_avgs_active(n_avgs_active), .win_cnt(win_cnt), .overflow(overflow),
        .overflow_clr(overflow_clr)
    );

    // One clock cycle: drive the beat, snapshot outputs at the falling edge, return just after the next rising edge.
    task automatic beat(input logic v, input logic l);
        fft_valid = v;
        fft_last = l;
        @(negedge clk);
        s_en = acc_en; s_clr = acc_clr; s_dump = acc_dump; s_pv = pkt_valid;
        s_ovf = overflow; s_nav = n_avgs_active; s_win = win_cnt;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        arest = 1'b1; enable = 1'b0; fft_valid = 1'b0; fft_last = 1'b0;
        pkt_ready = 1'b0; overflow_clr = 1'b0; n_avgs_cfg = '0;
        @(posedge clk);
        #1;
        arest = 1'b0;
    endtask

    // Enable, then one 4-beat frame consumed in SYNC; the next beat is the first accumulated one.
    task automatic sync_start(input logic [3:0] cfg);
        n_avgs_cfg = cfg;
        enable = 1'b1;
        beat(0, 0);
        repeat (3) beat(1, 0);
        beat(1, 1);
    endtask

    task automatic test_reset();
        do_reset();
        sync_start(1);
        for (int i = 0; i < 10; i++) beat(1, i % 2 == 1);
        fft_valid = 1'b1;
        arest = 1'b1;
        #2;
        checks++; if (acc_en !== 1'b0) begin errors++; $display("FAIL reset_acc_en got=%0b exp=0", acc_en); end
        checks++; if (acc_clr !== 1'b0) begin errors++; $display("FAIL reset_acc_clr got=%0b exp=0", acc_clr); end
        checks++; if (acc_dump !== 1'b0) begin errors++; $display("FAIL reset_acc_dump got=%0b exp=0", acc_dump); end
        checks++; if (pkt_valid !== 1'b0) begin errors++; $display("FAIL reset_pkt_valid got=%0b exp=0", pkt_valid); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got=%0b exp=0", overflow); end
        checks++; if (n_avgs_active !== 4'd0) begin errors++; $display("FAIL reset_n_avgs got=%0d exp=0", n_avgs_active); end
        checks++; if (win_cnt !== 16'd0) begin errors++; $display("FAIL reset_win_cnt got=%0d exp=0", win_cnt); end
        @(posedge clk);
        #1;
        arest = 1'b0;
    endtask

    task automatic test_basic_window();
        logic e_clr, e_dump, e_pv;
        do_reset();
        pkt_ready = 1'b1;
        sync_start(2);
        for (int i = 0; i < 36; i++) begin
            beat(1, i % 4 == 3);
            e_clr = (i % 16 == 0);
            e_dump = (i == 16 || i == 32);
            e_pv = (i == 18 || i == 34);
            checks++; if (s_en !== 1'b1) begin errors++; $display("FAIL basic_en i=%0d got=%0b exp=1", i, s_en); end
            checks++; if (s_clr !== e_clr) begin errors++; $display("FAIL basic_clr i=%0d got=%0b exp=%0b", i, s_clr, e_clr); end
            checks++; if (s_dump !== e_dump) begin errors++; $display("FAIL basic_dump i=%0d got=%0b exp=%0b", i, s_dump, e_dump); end
            checks++; if (s_pv !== e_pv) begin errors++; $display("FAIL basic_pkt_valid i=%0d got=%0b exp=%0b", i, s_pv, e_pv); end
            if (i == 20) begin
                checks++; if (s_win !== 16'd1) begin errors++; $display("FAIL basic_win_cnt got=%0d exp=1", s_win); end
            end
        end
    endtask

    task automatic test_mid_frame_start();
        do_reset();
        pkt_ready = 1'b1;
        n_avgs_cfg = 4'd2;
        beat(1, 0);
        beat(1, 0);
        enable = 1'b1;
        beat(1, 0);
        checks++; if (s_en !== 1'b0) begin errors++; $display("FAIL midframe_beat2_en got=%0b exp=0", s_en); end
        beat(1, 1);
        checks++; if (s_en !== 1'b0) begin errors++; $display("FAIL midframe_beat3_en got=%0b exp=0", s_en); end
        beat(1, 0);
        checks++; if (s_en !== 1'b1) begin errors++; $display("FAIL midframe_next_en got=%0b exp=1", s_en); end
        checks++; if (s_clr !== 1'b1) begin errors++; $display("FAIL midframe_next_clr got=%0b exp=1", s_clr); end
    endtask

    task automatic test_depth_change();
        logic e_clr, e_dump;
        logic [3:0] e_nav;
        do_reset();
        pkt_ready = 1'b1;
        sync_start(2);
        for (int i = 0; i < 28; i++) begin
            if (i == 4) n_avgs_cfg = 4'd0;
            beat(1, i % 4 == 3);
            e_dump = (i == 16 || i == 20 || i == 24);
            e_clr = (i == 0) || (i >= 16 && i % 4 == 0);
            e_nav = (i < 16) ? 4'd2 : 4'd0;
            checks++; if (s_dump !== e_dump) begin errors++; $display("FAIL depth_dump i=%0d got=%0b exp=%0b", i, s_dump, e_dump); end
            checks++; if (s_clr !== e_clr) begin errors++; $display("FAIL depth_clr i=%0d got=%0b exp=%0b", i, s_clr, e_clr); end
            checks++; if (s_nav !== e_nav) begin errors++; $display("FAIL depth_n_avgs i=%0d got=%0d exp=%0d", i, s_nav, e_nav); end
        end
    endtask

    task automatic test_overflow();
        do_reset();
        sync_start(0);
        for (int i = 0; i < 11; i++) begin
            beat(1, i % 4 == 3);
            if (i == 4 || i == 8) begin
                checks++; if (s_dump !== 1'b1) begin errors++; $display("FAIL ovf_dump i=%0d got=%0b exp=1", i, s_dump); end
            end
            if (i == 7) begin
                checks++; if (s_pv !== 1'b1) begin errors++; $display("FAIL ovf_first_valid got=%0b exp=1", s_pv); end
                checks++; if (s_ovf !== 1'b0) begin errors++; $display("FAIL ovf_early got=%0b exp=0", s_ovf); end
            end
            if (i == 9) begin
                checks++; if (s_ovf !== 1'b1) begin errors++; $display("FAIL ovf_set got=%0b exp=1", s_ovf); end
                checks++; if (s_pv !== 1'b0) begin errors++; $display("FAIL ovf_valid_drop got=%0b exp=0", s_pv); end
            end
            if (i == 10) begin
                checks++; if (s_pv !== 1'b1) begin errors++; $display("FAIL ovf_valid_new got=%0b exp=1", s_pv); end
            end
        end
        overflow_clr = 1'b1;
        beat(0, 0);
        overflow_clr = 1'b0;
        beat(0, 0);
        checks++; if (s_ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%0b exp=0", s_ovf); end
        checks++; if (s_pv !== 1'b1) begin errors++; $display("FAIL ovf_valid_held got=%0b exp=1", s_pv); end
    endtask

    // Continues from test_overflow: pkt_valid pending, frame of 4 beats three beats in.
    task automatic test_coincident_ready();
        beat(1, 1);
        pkt_ready = 1'b1;
        beat(0, 0);
        checks++; if (s_dump !== 1'b1) begin errors++; $display("FAIL coinc_dump got=%0b exp=1", s_dump); end
        checks++; if (s_pv !== 1'b1) begin errors++; $display("FAIL coinc_valid got=%0b exp=1", s_pv); end
        pkt_ready = 1'b0;
        beat(0, 0);
        checks++; if (s_ovf !== 1'b0) begin errors++; $display("FAIL coinc_overflow got=%0b exp=0", s_ovf); end
        checks++; if (s_pv !== 1'b0) begin errors++; $display("FAIL coinc_valid_drop got=%0b exp=0", s_pv); end
        checks++; if (s_win !== 16'd3) begin errors++; $display("FAIL coinc_win_cnt got=%0d exp=3", s_win); end
        beat(0, 0);
        checks++; if (s_pv !== 1'b1) begin errors++; $display("FAIL coinc_valid_new got=%0b exp=1", s_pv); end
    endtask

    task automatic test_stop_partial();
        do_reset();
        pkt_ready = 1'b1;
        sync_start(2);
        for (int i = 0; i < 16; i++) begin
            if (i == 8) enable = 1'b0;
            beat(1, i % 4 == 3);
            checks++; if (s_en !== (i < 12)) begin errors++; $display("FAIL stop_en i=%0d got=%0b exp=%0b", i, s_en, i < 12); end
            checks++; if (s_dump !== 1'b0) begin errors++; $display("FAIL stop_dump i=%0d got=%0b exp=0", i, s_dump); end
        end
        checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL stop_state got=%0d exp=%0d", dut.state, IDLE); end
        checks++; if (s_win !== 16'd0) begin errors++; $display("FAIL stop_win_cnt got=%0d exp=0", s_win); end
    endtask

    task automatic test_clamp();
        do_reset();
        n_avgs_cfg = 4'd9;
        enable = 1'b1;
        beat(0, 0);
        beat(0, 0);
        checks++; if (s_nav !== 4'd7) begin errors++; $display("FAIL clamp_n_avgs got=%0d exp=7", s_nav); end
        enable = 1'b0;
        beat(0, 0);
    endtask

    initial begin
        test_reset();
        test_basic_window();
        test_mid_frame_start();
        test_depth_change();
        test_overflow();
        test_coincident_ready();
        test_stop_partial();
        test_clamp();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
